// File: rtl/fault_cond_pkg.sv
// Shared register map and field positions for the fault-input conditioner.
package fault_cond_pkg;

  // Word offsets decoded from adr_i[4:2]
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_FILT   = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_IM     = 3'd3;
  localparam logic [2:0] REG_RIS    = 3'd4;
  localparam logic [2:0] REG_CLR    = 3'd5;

  localparam int CTRL_EN_LSB    = 0;
  localparam int CTRL_POL_LSB   = 8;
  localparam int CTRL_LATCH_LSB = 16;

  localparam int STAT_FAULT_LSB = 0;
  localparam int STAT_FILT_LSB  = 8;
  localparam int STAT_SYNC_LSB  = 16;

  localparam logic [31:0] RD_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fault_filter_ch.sv
// One fault channel: 2-flop sync, polarity, glitch filter, sticky latch, output flop.
module fault_filter_ch
  import fault_cond_pkg::*;
#(
  parameter int FILT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pad,
  input  logic              pol,
  input  logic              en,
  input  logic              latch_mode,
  input  logic [FILT_W-1:0] thresh,
  input  logic              clr,
  output logic              sync_raw,
  output logic              filt,
  output logic              fault,
  output logic              rise
);

  logic [1:0]        sync_q;
  logic [FILT_W-1:0] cnt;
  logic              lat;
  logic              s;

  assign sync_raw = sync_q[1];
  assign s        = sync_q[1] ^ pol;

  // Filtered level is about to go high on this edge
  assign rise = en & ~filt & s & (cnt == thresh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt    <= '0;
      filt   <= 1'b0;
      lat    <= 1'b0;
      fault  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pad};
      if (!en) begin
        cnt  <= '0;
        filt <= 1'b0;
        lat  <= 1'b0;
      end else begin
        if (s == filt) begin
          cnt <= '0;
        end else if (cnt == thresh) begin
          filt <= s;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        // A clear is refused while the fault is still present; a new rise beats it
        if (rise)
          lat <= 1'b1;
        else if (clr && !filt)
          lat <= 1'b0;
      end
      fault <= en & (latch_mode ? (lat | filt) : filt);
    end
  end

endmodule

// File: rtl/fault_conditioner_wb.sv
// Wishbone slave wrapping N_CH fault channels with a register file and level IRQ.
module fault_conditioner_wb
  import fault_cond_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int FILT_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     adr_i,
  input  logic [31:0]     dat_i,
  output logic [31:0]     dat_o,
  input  logic [3:0]      sel_i,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic            we_i,
  output logic            ack_o,
  input  logic [N_CH-1:0] fault_pad_i,
  output logic [N_CH-1:0] fault_o,
  output logic            irq_o
);

  logic [N_CH-1:0]   en, pol, latch_mode, im, ris;
  logic [N_CH-1:0]   sync_raw, filt, rise, clr, ris_clr;
  logic [FILT_W-1:0] thresh;
  logic [2:0]        idx;
  logic              req, wr;
  logic [31:0]       rd_data;
  logic              unused_bits;

  assign idx = adr_i[4:2];
  assign req = stb_i & cyc_i & ~ack_o;
  assign wr  = req & we_i;

  assign clr     = (wr && idx == REG_CLR && sel_i[0]) ? dat_i[N_CH-1:0] : '0;
  assign ris_clr = (wr && idx == REG_RIS && sel_i[0]) ? dat_i[N_CH-1:0] : '0;

  assign unused_bits = &{1'b0, adr_i[31:5], adr_i[1:0], dat_i, sel_i};

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    fault_filter_ch #(.FILT_W(FILT_W)) u_ch (
      .clk        (clk_i),
      .rst        (rst_i),
      .pad        (fault_pad_i[g]),
      .pol        (pol[g]),
      .en         (en[g]),
      .latch_mode (latch_mode[g]),
      .thresh     (thresh),
      .clr        (clr[g]),
      .sync_raw   (sync_raw[g]),
      .filt       (filt[g]),
      .fault      (fault_o[g]),
      .rise       (rise[g])
    );
  end

  always_comb begin
    rd_data = RD_DEFAULT;
    case (idx)
      REG_CTRL: begin
        for (int i = 0; i < N_CH; i++) begin
          rd_data[CTRL_EN_LSB + i]    = en[i];
          rd_data[CTRL_POL_LSB + i]   = pol[i];
          rd_data[CTRL_LATCH_LSB + i] = latch_mode[i];
        end
      end
      REG_FILT: rd_data[FILT_W-1:0] = thresh;
      REG_STATUS: begin
        for (int i = 0; i < N_CH; i++) begin
          rd_data[STAT_FAULT_LSB + i] = fault_o[i];
          rd_data[STAT_FILT_LSB + i]  = filt[i];
          rd_data[STAT_SYNC_LSB + i]  = sync_raw[i];
        end
      end
      REG_IM:  rd_data[N_CH-1:0] = im;
      REG_RIS: rd_data[N_CH-1:0] = ris;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o      <= 1'b0;
      dat_o      <= RD_DEFAULT;
      en         <= '0;
      pol        <= '0;
      latch_mode <= '0;
      thresh     <= '0;
      im         <= '0;
      ris        <= '0;
      irq_o      <= 1'b0;
    end else begin
      ack_o <= req;
      dat_o <= (req && !we_i) ? rd_data : RD_DEFAULT;
      if (wr && idx == REG_CTRL) begin
        for (int i = 0; i < N_CH; i++) begin
          if (sel_i[0]) en[i]         <= dat_i[CTRL_EN_LSB + i];
          if (sel_i[1]) pol[i]        <= dat_i[CTRL_POL_LSB + i];
          if (sel_i[2]) latch_mode[i] <= dat_i[CTRL_LATCH_LSB + i];
        end
      end
      if (wr && idx == REG_FILT) begin
        for (int j = 0; j < FILT_W; j++)
          if (sel_i[j / 8]) thresh[j] <= dat_i[j];
      end
      if (wr && idx == REG_IM && sel_i[0])
        im <= dat_i[N_CH-1:0];
      // Set wins over a simultaneous W1C
      ris   <= (ris & ~ris_clr) | rise;
      irq_o <= |(ris & im);
    end
  end

endmodule
